block_map_rd_arbiter: RTL and testbench

Shares the single read port of the arena block-map RAM between several requesters: bomberman collision logic, enemy direction checks and explosion-extent lookup. Arbitration is round-robin, with one outstanding read at a time. Each requester gets a one-hot grant pulse, then a valid pulse carrying the returned tile code. It sits between the requesters and the block-map BRAM in the top level.

---
 rtl/bm_arena_pkg.sv | 40 ++++
 rtl/block_map_rd_arbiter_rr_pick.sv | 39 +++
 rtl/block_map_rd_arbiter.sv | 131 +++++++++++++
 tb/tb_block_map_rd_arbiter.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_arena_pkg.sv
// Shared arena definitions: block-map geometry, tile codes, requester ids, read arbiter states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bm_arena_pkg;

  // Block-map geometry: 33 columns x 27 rows, row-major, one tile per word
  localparam int ABM_COLS   = 33;
  localparam int ABM_ROWS   = 27;
  localparam int ABM_TILES  = ABM_COLS * ABM_ROWS;
  localparam int ABM_ADDR_W = 11;
  localparam int ABM_TILE_W = 2;

  // Tile codes stored in the block map
  typedef enum logic [ABM_TILE_W-1:0] {
    TILE_EMPTY  = 2'd0,
    TILE_PILLAR = 2'd1,
    TILE_WALL   = 2'd2,
    TILE_EXIT   = 2'd3
  } tile_e;

  // Requester slots on the block-map read arbiter
  localparam int ABM_N_REQ = 4;
  localparam int REQ_BM    = 0;
  localparam int REQ_EN0   = 1;
  localparam int REQ_EN1   = 2;
  localparam int REQ_EXP   = 3;

  // Read arbiter state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Row-major tile address of (col,row); no range check
  function automatic logic [ABM_ADDR_W-1:0] abm_tile_addr(input int col, input int row);
    return ABM_ADDR_W'(row * ABM_COLS + col);
  endfunction

endpackage

// File: rtl/block_map_rd_arbiter_rr_pick.sv
// Round-robin priority pick: first set req bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  localparam int DBL_W  = 2 * N;
  localparam int DIDX_W = $clog2(DBL_W);

  logic [DBL_W-1:0]  dbl;
  logic [DBL_W-1:0]  masked;
  logic [DIDX_W-1:0] hit;

  // Duplicate req, drop bits below ptr, take the lowest survivor: the upper copy supplies the wrap
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({DBL_W{1'b1}} << ptr);
    hit    = '0;
    for (int i = DBL_W - 1; i >= 0; i--) begin
      if (masked[i]) begin
        hit = DIDX_W'(i);
      end
    end
    if (int'(hit) >= N) begin
      winner = IDX_W'(int'(hit) - N);
    end else begin
      winner = IDX_W'(hit);
    end
    any = |req;
  end

endmodule

// File: rtl/block_map_rd_arbiter.sv
// Round-robin share of the block-map BRAM read port, one outstanding read at a time.
// Latency: req at T -> gnt/mem_en at T+1 -> rvalid/rdata at T+1+RD_LAT; next pick at T+2+RD_LAT.
// Backpressure: req is sampled only while idle; unserved requesters simply wait with req held.
module block_map_rd_arbiter
  import bm_arena_pkg::*;
#(
  parameter int N_REQ  = ABM_N_REQ,
  parameter int ADDR_W = ABM_ADDR_W,
  parameter int DATA_W = ABM_TILE_W,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_dout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_win;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_win)
  );

  // Next-state and registered-output decode; gnt/mem_en/rvalid default low so they pulse one cycle
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d[pick_win] = 1'b1;
          mem_en_d        = 1'b1;
          mem_addr_d      = addr[int'(pick_win)*ADDR_W +: ADDR_W];
          sel_d           = pick_win;
          cnt_d           = '0;
          state_d         = WAIT;
          if (int'(pick_win) == N_REQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = pick_win + 1'b1;
          end
        end
      end
      WAIT: begin
        // Last of RD_LAT wait cycles: BRAM output is valid, capture and flag the owner
        if (cnt_q == CNT_LAST) begin
          rdata_d         = mem_dout;
          rvalid_d[sel_q] = 1'b1;
          cnt_d           = '0;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any read in flight and restarts priority at requester 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_block_map_rd_arbiter.sv
// Bench for block_map_rd_arbiter: three instances (RD_LAT 1,2,3) against a timeline reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_block_map_rd_arbiter;
  import bm_arena_pkg::*;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 2;
  localparam int NI = 3;
  localparam int VW = N + N + DW + 1 + 1 + AW;
  typedef logic [N*AW-1:0] addr_vec_t;
  typedef logic [VW-1:0]   vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]    req      [NI];
  logic [N*AW-1:0] addr     [NI];
  logic [N-1:0]    gnt      [NI];
  logic [N-1:0]    rvalid   [NI];
  logic [DW-1:0]   rdata    [NI];
  logic            busy     [NI];
  logic            mem_en   [NI];
  logic [AW-1:0]   mem_addr [NI];
  logic [DW-1:0]   mem_dout [NI];
  logic [DW-1:0]   mem      [0:2047];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: age = cycles since the grant decision (-1 = never granted)
  int            m_age   [NI];
  int            m_ptr   [NI];
  int            m_sel   [NI];
  logic [AW-1:0] m_addr  [NI];
  logic [DW-1:0] m_rdata [NI];

  int log_k;
  int log_who[$];
  int log_gc[$];
  int log_rc[$];
  int log_rd[$];
  int log_en;
  int dc[NI][N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    block_map_rd_arbiter #(
      .N_REQ  (N),
      .ADDR_W (AW),
      .DATA_W (DW),
      .RD_LAT (g + 1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req[g]),
      .addr     (addr[g]),
      .gnt      (gnt[g]),
      .rvalid   (rvalid[g]),
      .rdata    (rdata[g]),
      .busy     (busy[g]),
      .mem_en   (mem_en[g]),
      .mem_addr (mem_addr[g]),
      .mem_dout (mem_dout[g])
    );
    // BRAM stand-in: mem_addr is registered and held, so its output is settled by the capture edge
    assign mem_dout[g] = mem[mem_addr[g]];
  end

  function automatic void m_reset(int k);
    m_age[k]   = -1;
    m_ptr[k]   = 0;
    m_sel[k]   = 0;
    m_addr[k]  = '0;
    m_rdata[k] = '0;
  endfunction

  // Advance instance k across one clock edge using the req/addr present at that edge
  function automatic void m_step(int k);
    int lat;
    bit found;
    lat = k + 1;
    if (reset) begin
      m_reset(k);
      return;
    end
    if ((m_age[k] < 0 || m_age[k] >= lat + 2) && req[k] != '0) begin
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        int c;
        c = (m_ptr[k] + j) % N;
        if (!found && req[k][c]) begin
          found    = 1'b1;
          m_sel[k] = c;
        end
      end
      m_addr[k] = addr[k][m_sel[k]*AW +: AW];
      m_ptr[k]  = (m_sel[k] + 1) % N;
      m_age[k]  = 0;
    end
    if (m_age[k] >= 0 && m_age[k] < 100) m_age[k]++;
    if (m_age[k] == lat + 1) m_rdata[k] = mem[m_addr[k]];
  endfunction

  function automatic vec_t exp_v(int k);
    logic [N-1:0] oh;
    logic [N-1:0] g;
    logic [N-1:0] rv;
    int lat;
    lat = k + 1;
    oh = '0;
    oh[m_sel[k]] = 1'b1;
    g  = (m_age[k] == 1) ? oh : '0;
    rv = (m_age[k] == lat + 1) ? oh : '0;
    return {g, rv, m_rdata[k], (m_age[k] >= 1 && m_age[k] <= lat + 1), (m_age[k] == 1), m_addr[k]};
  endfunction

  function automatic vec_t obs_v(int k);
    return {gnt[k], rvalid[k], rdata[k], busy[k], mem_en[k], mem_addr[k]};
  endfunction

  function automatic int oh2i(logic [N-1:0] v);
    int r;
    r = -1;
    for (int j = N - 1; j >= 0; j--) if (v[j]) r = j;
    return r;
  endfunction

  function automatic void clear_logs(int k);
    log_k = k;
    log_who.delete();
    log_gc.delete();
    log_rc.delete();
    log_rd.delete();
    log_en = 0;
    for (int a = 0; a < NI; a++) for (int b = 0; b < N; b++) dc[a][b] = 0;
  endfunction

  // Bookkeeping of what the logged instance did this cycle; also arms requester drop timers
  function automatic void log_cycle();
    if (gnt[log_k] != '0) begin
      log_who.push_back(oh2i(gnt[log_k]));
      log_gc.push_back(cyc);
    end
    if (rvalid[log_k] != '0) begin
      log_rc.push_back(cyc);
      log_rd.push_back(int'(rdata[log_k]));
    end
    if (mem_en[log_k]) log_en++;
    for (int a = 0; a < NI; a++) for (int b = 0; b < N; b++) if (gnt[a][b]) dc[a][b] = 2;
  endfunction

  // Saturating requester: keeps req through the gnt cycle, drops it one cycle, then re-raises
  function automatic logic sat_bit(int k, int j);
    if (dc[k][j] == 2) begin
      dc[k][j] = 1;
      return 1'b1;
    end else if (dc[k][j] == 1) begin
      dc[k][j] = 0;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req[k] = '0;
      m_reset(k);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
    for (int k = 0; k < NI; k++) begin
      req[k]  = '0;
      addr[k] = addr_vec_t'({$urandom, $urandom});
    end
    #1 reset = 1'b1;
    for (int k = 0; k < NI; k++) m_reset(k);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (obs_v(k) !== vec_t'(0)) begin
        n_fail++;
        $display("FAIL reset_async inst%0d: got %h expected %h", k, obs_v(k), vec_t'(0));
      end
    end
    for (int k = 0; k < NI; k++) req[k] = 4'b1111;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (obs_v(k) !== vec_t'(0)) begin
        n_fail++;
        $display("FAIL reset_clocked inst%0d: got %h expected %h", k, obs_v(k), vec_t'(0));
      end
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    clear_logs(0);
    mem[11'h05A] = TILE_WALL;
    addr[0] = addr_vec_t'({$urandom, $urandom});
    addr[0][2*AW +: AW] = 11'h05A;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req[0] = (c == 0) ? 4'b0100 : 4'b0000;
      req[1] = '0;
      req[2] = '0;
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < NI; k++) begin
        m_step(k); n_chk++;
        if (obs_v(k) !== exp_v(k)) begin
          n_fail++;
          $display("FAIL single inst%0d cyc%0d: got %h expected %h", k, cyc, obs_v(k), exp_v(k));
        end
      end
      log_cycle();
      if (c == 0) begin
        n_chk++;
        if ({gnt[0], mem_addr[0]} !== {4'b0100, 11'h05A}) begin
          n_fail++;
          $display("FAIL single_gnt: got gnt=%b addr=%h expected gnt=0100 addr=05a", gnt[0], mem_addr[0]);
        end
      end
      if (c == 1) begin
        n_chk++;
        if ({rvalid[0], rdata[0]} !== {4'b0100, 2'd2}) begin
          n_fail++;
          $display("FAIL single_rvalid: got rvalid=%b rdata=%0d expected rvalid=0100 rdata=2", rvalid[0], rdata[0]);
        end
      end
      if (c == 2) begin
        n_chk++;
        if (busy[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL single_busy: got %b expected 0", busy[0]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] p;
    int rounds;
    int exp_who[4] = '{0, 1, 0, 1};
    apply_reset();
    clear_logs(0);
    addr[0] = addr_vec_t'({$urandom, $urandom});
    p = 4'b0011;
    rounds = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (p == '0 && rounds == 0) begin
        p = 4'b0011;
        rounds = 1;
      end
      req[0] = p;
      req[1] = '0;
      req[2] = '0;
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < NI; k++) begin
        m_step(k); n_chk++;
        if (obs_v(k) !== exp_v(k)) begin
          n_fail++;
          $display("FAIL simultaneous inst%0d cyc%0d: got %h expected %h", k, cyc, obs_v(k), exp_v(k));
        end
      end
      log_cycle();
      p = p & ~gnt[0];
    end
    n_chk++;
    if (log_who.size() != 4) begin
      n_fail++;
      $display("FAIL simul_count: got %0d grants expected 4", log_who.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (log_who[i] != exp_who[i]) begin
          n_fail++;
          $display("FAIL simul_order[%0d]: got %0d expected %0d", i, log_who[i], exp_who[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (log_gc[i+1] - log_gc[i] != 3) begin
          n_fail++;
          $display("FAIL simul_gap[%0d]: got %0d expected 3", i, log_gc[i+1] - log_gc[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    clear_logs(0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        for (int j = 0; j < N; j++) req[k][j] = sat_bit(k, j);
        addr[k] = addr_vec_t'({$urandom, $urandom});
      end
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < NI; k++) begin
        m_step(k); n_chk++;
        if (obs_v(k) !== exp_v(k)) begin
          n_fail++;
          $display("FAIL saturation inst%0d cyc%0d: got %h expected %h", k, cyc, obs_v(k), exp_v(k));
        end
      end
      log_cycle();
    end
    n_chk++;
    if (log_who.size() < 13) begin
      n_fail++;
      $display("FAIL sat_count: got %0d grants expected at least 13", log_who.size());
    end
    for (int i = 0; i < log_who.size(); i++) begin
      n_chk++;
      if (log_who[i] != i % N) begin
        n_fail++;
        $display("FAIL sat_order[%0d]: got %0d expected %0d", i, log_who[i], i % N);
      end
      if (i > 0) begin
        n_chk++;
        if (log_gc[i] - log_gc[i-1] != 3) begin
          n_fail++;
          $display("FAIL sat_gap[%0d]: got %0d expected 3", i, log_gc[i] - log_gc[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    clear_logs(2);
    addr[2] = addr_vec_t'({$urandom, $urandom});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) reset = 1'b0;
      req[0] = '0;
      req[1] = '0;
      req[2] = (c < 4) ? 4'b0010 : 4'b0000;
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < NI; k++) begin
        m_step(k); n_chk++;
        if (obs_v(k) !== exp_v(k)) begin
          n_fail++;
          $display("FAIL reset_mid inst%0d cyc%0d: got %h expected %h", k, cyc, obs_v(k), exp_v(k));
        end
      end
      log_cycle();
      if (c == 1) begin
        // Second WAIT cycle of the RD_LAT=3 read: pull reset mid-cycle
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
          m_reset(k);
          n_chk++;
          if (obs_v(k) !== vec_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_async inst%0d: got %h expected %h", k, obs_v(k), vec_t'(0));
          end
        end
      end
      if (c == 3) begin
        n_chk++;
        if (gnt[2] !== 4'b0010) begin
          n_fail++;
          $display("FAIL reset_mid_regrant: got %b expected 0010", gnt[2]);
        end
      end
    end
    n_chk++;
    if (log_rc.size() != 1 || log_gc.size() != 2) begin
      n_fail++;
      $display("FAIL reset_mid_pulses: got %0d rvalid %0d gnt expected 1 rvalid 2 gnt", log_rc.size(), log_gc.size());
    end
  endtask

  task automatic test_held();
    int base;
    apply_reset();
    clear_logs(0);
    addr[0] = addr_vec_t'({$urandom, $urandom});
    base = cyc;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req[0] = (c < 5) ? 4'b0001 : 4'b0000;
      req[1] = '0;
      req[2] = '0;
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < NI; k++) begin
        m_step(k); n_chk++;
        if (obs_v(k) !== exp_v(k)) begin
          n_fail++;
          $display("FAIL held inst%0d cyc%0d: got %h expected %h", k, cyc, obs_v(k), exp_v(k));
        end
      end
      log_cycle();
    end
    n_chk++;
    if (log_gc.size() != 2 || log_rc.size() != 2) begin
      n_fail++;
      $display("FAIL held_count: got %0d gnt %0d rvalid expected 2 and 2", log_gc.size(), log_rc.size());
    end else begin
      n_chk++;
      if (log_gc[0] != base + 1 || log_gc[1] != base + 4) begin
        n_fail++;
        $display("FAIL held_gnt_time: got +%0d +%0d expected +1 +4", log_gc[0] - base, log_gc[1] - base);
      end
      n_chk++;
      if (log_rc[0] != base + 2 || log_rc[1] != base + 5) begin
        n_fail++;
        $display("FAIL held_rvalid_time: got +%0d +%0d expected +2 +5", log_rc[0] - base, log_rc[1] - base);
      end
    end
  endtask

  task automatic test_lat2_last_tile();
    int base;
    apply_reset();
    clear_logs(1);
    mem[abm_tile_addr(ABM_COLS - 1, ABM_ROWS - 1)] = TILE_EXIT;
    mem[0] = TILE_PILLAR;
    addr[1] = addr_vec_t'({$urandom, $urandom});
    addr[1][3*AW +: AW] = 11'h37A;
    addr[1][0 +: AW]    = 11'h000;
    base = cyc;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req[0] = '0;
      req[1] = (c == 0) ? 4'b1000 : (c == 5) ? 4'b0001 : 4'b0000;
      req[2] = '0;
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < NI; k++) begin
        m_step(k); n_chk++;
        if (obs_v(k) !== exp_v(k)) begin
          n_fail++;
          $display("FAIL lat2 inst%0d cyc%0d: got %h expected %h", k, cyc, obs_v(k), exp_v(k));
        end
      end
      log_cycle();
    end
    n_chk++;
    if (log_en != 2) begin
      n_fail++;
      $display("FAIL lat2_mem_en: got %0d cycles expected 2", log_en);
    end
    n_chk++;
    if (log_rc.size() != 2) begin
      n_fail++;
      $display("FAIL lat2_rvalid_count: got %0d expected 2", log_rc.size());
    end else begin
      n_chk++;
      if (log_rc[0] != base + 3 || log_rd[0] != 3) begin
        n_fail++;
        $display("FAIL lat2_last_tile: got +%0d data %0d expected +3 data 3", log_rc[0] - base, log_rd[0]);
      end
      n_chk++;
      if (log_rd[1] != 1) begin
        n_fail++;
        $display("FAIL lat2_tile0: got %0d expected 1", log_rd[1]);
      end
    end
  endtask

  task automatic test_random();
    clear_logs(0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < NI; k++) begin
        req[k]  = N'($urandom) & N'($urandom);
        addr[k] = addr_vec_t'({$urandom, $urandom});
      end
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < NI; k++) begin
        m_step(k); n_chk++;
        if (obs_v(k) !== exp_v(k)) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: got %h expected %h", k, cyc, obs_v(k), exp_v(k));
        end
      end
      log_cycle();
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_saturation();
    test_reset_mid_wait();
    test_held();
    test_lat2_last_tile();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
